dsp_shared_arbiter: RTL and testbench

- Shares one DSP_INOUT_REGISTERED-style pipelined DSP (2-bit a/b, mode bit m, 4-bit out) between NUM_REQ requesters.
- Each cycle, arbitrates one valid request onto the DSP input ports.
- Tracks in-flight operations with a tag pipeline matched to the DSP latency (input register + output register = 2 cycles).
- Returns each result tagged with its requester ID. Sits between requester logic and the DSP instance; contains no arithmetic.

---
 rtl/dsp_shared_arbiter_pkg.sv | 13 +
 rtl/dsp_rr_arbiter.sv | 35 +++
 rtl/dsp_shared_arbiter.sv | 100 ++++++++++
 tb/tb_dsp_shared_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_shared_arbiter_pkg.sv
// Shared constants and slice helper for the DSP sharing arbiter and its sub-blocks.
package dsp_shared_arbiter_pkg;

  // Must equal the register stages inside the shared DSP (input DFF + output DFF).
  localparam int DSP_ARB_LATENCY  = 2;
  localparam int DSP_ARB_ID_WIDTH = 2;

  // Low bit of requester idx's operand slice in a packed request bus.
  function automatic int op_lsb(input int idx, input int op_w);
    return idx * op_w;
  endfunction

endpackage

// File: rtl/dsp_rr_arbiter.sv
// Round-robin arbiter: request vector plus start pointer -> one-hot grant and encoded id.
module dsp_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                grant_vld
);

  int                  sum;
  logic [ID_WIDTH-1:0] idx;

  // ptr is the first index searched; the first active request found from there wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = int'(ptr) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_WIDTH'(sum);
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_shared_arbiter.sv
// Shares one 2-stage registered DSP among NUM_REQ requesters and tags each result with its owner.
// Define DSP_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module dsp_shared_arbiter
  import dsp_shared_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int LATENCY    = DSP_ARB_LATENCY,
  parameter int ID_WIDTH   = DSP_ARB_ID_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*(DATA_WIDTH/2)-1:0] req_a,
  input  logic [NUM_REQ*(DATA_WIDTH/2)-1:0] req_b,
  input  logic [NUM_REQ-1:0]                req_m,
  output logic [DATA_WIDTH/2-1:0]           dsp_a,
  output logic [DATA_WIDTH/2-1:0]           dsp_b,
  output logic                              dsp_m,
  input  logic [DATA_WIDTH-1:0]             dsp_out,
  output logic                              rsp_valid,
  output logic [ID_WIDTH-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic                              busy
);

  localparam int OP_W = DATA_WIDTH / 2;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_vld;
  logic                accept;
  logic [ID_WIDTH-1:0] ptr;
  logic [LATENCY-1:0]  vld_p;
  logic [ID_WIDTH-1:0] id_p [LATENCY];

  dsp_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  assign req_ready = rst ? '0 : grant;
  assign accept    = grant_vld & ~rst;

`ifdef DSP_ARB_FIXED_PRIO_EN
  // Searching always from index 0 turns the round-robin search into fixed priority.
  assign ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
    end
  end
`endif

  // Issue: one-hot OR-mux of the granted operands; zeros when nothing is granted.
  always_comb begin
    dsp_a = '0;
    dsp_b = '0;
    dsp_m = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        dsp_a = dsp_a | req_a[op_lsb(i, OP_W) +: OP_W];
        dsp_b = dsp_b | req_b[op_lsb(i, OP_W) +: OP_W];
        dsp_m = dsp_m | req_m[i];
      end
    end
  end

  // Stage p0 .. p(LATENCY-1): tag pipeline tracking the DSP's internal registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    id_p[0] <= grant_id;
    for (int s = 1; s < LATENCY; s++) id_p[s] <= id_p[s-1];
  end

  // Retire: last tag stage lines up with the DSP's registered output.
  assign rsp_valid = vld_p[LATENCY-1];
  assign rsp_id    = rsp_valid ? id_p[LATENCY-1] : '0;
  assign rsp_data  = rsp_valid ? dsp_out : '0;
  assign busy      = |vld_p;

endmodule

// File: tb/tb_dsp_shared_arbiter.sv
// Directed bench for dsp_shared_arbiter with a behavioural 2-register DSP (m ? a*b : a+b).
module tb_dsp_shared_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_ready, req_m;
  logic [7:0] req_a, req_b;
  logic [1:0] dsp_a, dsp_b;
  logic       dsp_m;
  logic [3:0] dsp_out;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [3:0] rsp_data;
  logic       busy;

  logic [1:0] mdl_a, mdl_b;
  logic       mdl_m;

  int checks = 0;
  int errors = 0;

  logic [3:0] fair_data [4];
  logic [3:0] pat_rdy [4];
  logic [1:0] pat_id [4];

  always #5 clk = ~clk;

  dsp_shared_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (4),
    .LATENCY    (2),
    .ID_WIDTH   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_m     (req_m),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_m     (dsp_m),
    .dsp_out   (dsp_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // DSP model: input register then output register.
  always_ff @(posedge clk) begin
    mdl_a   <= dsp_a;
    mdl_b   <= dsp_b;
    mdl_m   <= dsp_m;
    dsp_out <= mdl_m ? ({2'b00, mdl_a} * {2'b00, mdl_b}) : ({2'b00, mdl_a} + {2'b00, mdl_b});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fair_data = '{4'd0, 4'd1, 4'd4, 4'd9};
`ifdef DSP_ARB_FIXED_PRIO_EN
    pat_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    pat_id  = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    pat_rdy = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    pat_id  = '{2'd2, 2'd0, 2'd2, 2'd0};
`endif

    // Reset with every requester asking
    rst = 1'b1; req_valid = 4'hF; req_a = 8'hFF; req_b = 8'hFF; req_m = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_dsp_a", dsp_a, 2'b00);
      chk("rst_dsp_b", dsp_b, 2'b00);
      chk("rst_dsp_m", dsp_m, 1'b0);
      chk("rst_rsp_id", rsp_id, 2'd0);
      chk("rst_rsp_data", rsp_data, 4'd0);
    end
    rst = 1'b0; req_valid = 4'h0;
    #1;
    chk("idle_ready", req_ready, 4'b0000);
    chk("idle_dsp_a", dsp_a, 2'b00);
    tick();

    // Single op from requester 2: 3*2 = 6
    req_valid = 4'b0100; req_a = 8'b00_11_00_00; req_b = 8'b00_10_00_00; req_m = 4'b0100;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    chk("single_dsp_a", dsp_a, 2'b11);
    chk("single_dsp_b", dsp_b, 2'b10);
    chk("single_dsp_m", dsp_m, 1'b1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_busy1", busy, 1'b1);
    chk("single_early_valid", rsp_valid, 1'b0);
    chk("single_idle_dsp_a", dsp_a, 2'b00);
    tick();
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_rsp_id", rsp_id, 2'd2);
    chk("single_rsp_data", rsp_data, 4'b0110);
    chk("single_busy2", busy, 1'b1);
    tick();
    chk("single_after_valid", rsp_valid, 1'b0);
    chk("single_after_busy", busy, 1'b0);
    chk("single_after_id", rsp_id, 2'd0);
    chk("single_after_data", rsp_data, 4'd0);

    // Fairness from a fresh pointer: a_i = b_i = i, odd ids multiply
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = {2'd3, 2'd2, 2'd1, 2'd0}; req_b = {2'd3, 2'd2, 2'd1, 2'd0}; req_m = 4'b1010;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) begin
        chk("fair_ready", req_ready, 32'd1 << (k % 4));
        chk("fair_dsp_a", dsp_a, k % 4);
      end
      if (k >= 2) begin
        chk("fair_rsp_valid", rsp_valid, 1'b1);
        chk("fair_rsp_id", rsp_id, (k - 2) % 4);
        chk("fair_rsp_data", rsp_data, fair_data[(k - 2) % 4]);
      end
      tick();
    end
    chk("fair_drain_valid", rsp_valid, 1'b0);
    chk("fair_drain_busy", busy, 1'b0);

    // Sparse contention between 1 and 3 with an idle gap
    req_valid = 4'b0010; #1;
    chk("sparse_g1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010; #1;
    chk("sparse_g3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000; #1;
    chk("sparse_idle_ready", req_ready, 4'b0000);
    chk("sparse_rsp1_valid", rsp_valid, 1'b1);
    chk("sparse_rsp1_id", rsp_id, 2'd1);
    tick();
    req_valid = 4'b1010; #1;
    chk("sparse_g1_again", req_ready, 4'b0010);
    chk("sparse_rsp3_id", rsp_id, 2'd3);
    tick();
    req_valid = 4'b0000; #1;
    chk("sparse_gap_rsp", rsp_valid, 1'b0);
    tick();
    req_valid = 4'b0011; #1;
    chk("sparse_wrap_g0", req_ready, 4'b0001);
    chk("sparse_rsp1b_id", rsp_id, 2'd1);
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();

    // Reset while ops for ids 0 and 1 are in flight
    req_valid = 4'b0001; #1;
    chk("midrst_g0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010; #1;
    chk("midrst_g1", req_ready, 4'b0010);
    tick();
    rst = 1'b1; req_valid = 4'b0000;
    tick();
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    tick();
    chk("midrst_rsp_valid2", rsp_valid, 1'b0);
    rst = 1'b0; req_valid = 4'hF; #1;
    chk("midrst_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000; #1;
    chk("midrst_post_busy", busy, 1'b1);
    chk("midrst_post_novalid", rsp_valid, 1'b0);
    tick();
    chk("midrst_post_rsp", rsp_valid, 1'b1);
    chk("midrst_post_id", rsp_id, 2'd0);
    tick();

    // Requesters 0 and 2 held valid
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 4'b0101 : 4'b0000;
      #1;
      if (k < 4) chk("pat_ready", req_ready, pat_rdy[k]);
      if (k >= 2) begin
        chk("pat_rsp_valid", rsp_valid, 1'b1);
        chk("pat_rsp_id", rsp_id, pat_id[k - 2]);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
